// File: rtl/capture_mode_ctrl.sv
// Camera/display pipeline sequencer: camera configuration handshake, capture gating and
// vsync-aligned calibration/game mode switching.
module capture_mode_ctrl #(
    parameter int unsigned HOLD_CYCLES  = 5000000,
    parameter int unsigned RESEND_PULSE = 16,
    parameter int unsigned CFG_TIMEOUT  = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_calib,
    input  logic       btn_resend,
    input  logic       config_done,
    input  logic       cam_vsync,
    input  logic       disp_vsync,
    output logic       cfg_resend,
    output logic       capture_en,
    output logic       calib,
    output logic       cfg_error,
    output logic [2:0] state
);

    localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned PulseW = (RESEND_PULSE > 1) ? $clog2(RESEND_PULSE) : 1;
    localparam int unsigned TmoW   = (CFG_TIMEOUT > 1) ? $clog2(CFG_TIMEOUT) : 1;

    localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_CYCLES - 1);
    localparam logic [PulseW-1:0] PulseLast = PulseW'(RESEND_PULSE - 1);
    localparam logic [TmoW-1:0]   TmoLast   = TmoW'(CFG_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StConfig  = 3'd0,
        StWaitCfg = 3'd1,
        StArm     = 3'd2,
        StRun     = 3'd3,
        StError   = 3'd4
    } state_e;

    state_e             st;
    logic               cam_meta, cam_sync, cam_prev;
    logic               resend_prev, disp_prev;
    logic [HoldW-1:0]   hold_cnt;
    logic               hold_done;
    logic               pending;
    logic [PulseW-1:0]  pulse_cnt;
    logic [TmoW-1:0]    tmo_cnt;
    logic               seen_low;

    logic resend_req, cam_rise, disp_rise, toggle_req;

    assign state      = st;
    assign resend_req = btn_resend & ~resend_prev & (st != StConfig);
    assign cam_rise   = cam_sync & ~cam_prev;
    assign disp_rise  = disp_vsync & ~disp_prev;
    // hold_done keeps a long press from firing more than once
    assign toggle_req = btn_calib & ~hold_done & (hold_cnt == HoldLast) &
                        ((st == StArm) | (st == StRun));

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= StConfig;
            cfg_resend  <= 1'b1;
            capture_en  <= 1'b0;
            calib       <= 1'b1;
            cfg_error   <= 1'b0;
            cam_meta    <= 1'b0;
            cam_sync    <= 1'b0;
            cam_prev    <= 1'b0;
            resend_prev <= 1'b0;
            disp_prev   <= 1'b0;
            hold_cnt    <= '0;
            hold_done   <= 1'b0;
            pending     <= 1'b0;
            pulse_cnt   <= '0;
            tmo_cnt     <= '0;
            seen_low    <= 1'b0;
        end else begin
            cam_meta    <= cam_vsync;
            cam_sync    <= cam_meta;
            cam_prev    <= cam_sync;
            resend_prev <= btn_resend;
            disp_prev   <= disp_vsync;

            if (!btn_calib) begin
                hold_cnt  <= '0;
                hold_done <= 1'b0;
            end else if (hold_cnt != HoldLast) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_done <= 1'b1;
            end

            if (resend_req) begin
                st         <= StConfig;
                cfg_resend <= 1'b1;
                capture_en <= 1'b0;
                cfg_error  <= 1'b0;
                pulse_cnt  <= '0;
                pending    <= 1'b0;
            end else begin
                // Apply the old pending switch first, then latch any new request
                if (disp_rise && pending) begin
                    calib   <= ~calib;
                    pending <= toggle_req;
                end else if (toggle_req) begin
                    pending <= ~pending;
                end

                case (st)
                    StConfig: begin
                        if (pulse_cnt == PulseLast) begin
                            st         <= StWaitCfg;
                            cfg_resend <= 1'b0;
                            tmo_cnt    <= '0;
                            seen_low   <= 1'b0;
                        end else begin
                            pulse_cnt <= pulse_cnt + 1'b1;
                        end
                    end
                    StWaitCfg: begin
                        if (!config_done) seen_low <= 1'b1;
                        if (config_done && seen_low) begin
                            st <= StArm;
                        end else if (tmo_cnt == TmoLast) begin
                            st        <= StError;
                            cfg_error <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    StArm: begin
                        if (cam_rise) begin
                            st         <= StRun;
                            capture_en <= 1'b1;
                        end
                    end
                    StRun, StError: ;
                    default: begin
                        st         <= StConfig;
                        cfg_resend <= 1'b1;
                        capture_en <= 1'b0;
                        pulse_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_mode_ctrl.sv
// Scoreboard bench for capture_mode_ctrl: a behavioural model predicts the outputs after every
// clock edge, a separate monitor compares them with the DUT.
module tb_capture_mode_ctrl;

    localparam int unsigned HOLD  = 8;
    localparam int unsigned PULSE = 16;
    localparam int unsigned TMO   = 100;

    localparam logic [2:0] S_CONFIG = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_calib = 1'b0;
    logic       btn_resend = 1'b0;
    logic       config_done = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       disp_vsync = 1'b0;
    logic       cfg_resend, capture_en, calib, cfg_error;
    logic [2:0] state;

    capture_mode_ctrl #(
        .HOLD_CYCLES (HOLD),
        .RESEND_PULSE(PULSE),
        .CFG_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_calib  (btn_calib),
        .btn_resend (btn_resend),
        .config_done(config_done),
        .cam_vsync  (cam_vsync),
        .disp_vsync (disp_vsync),
        .cfg_resend (cfg_resend),
        .capture_en (capture_en),
        .calib      (calib),
        .cfg_error  (cfg_error),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] e_state;
        logic       e_resend;
        logic       e_cap;
        logic       e_calib;
        logic       e_err;
    } exp_t;

    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cycle = 0;
    string phase = "reset";

    // Behavioural model: mode, cycles spent in the current mode, length of the current press
    logic [2:0] m_state;
    int         m_age;
    int         m_hold_len;
    bit         m_seen_low, m_pending, m_calib, m_err;
    bit         m_btn_prev, m_disp_prev;
    bit         cam_h[3];

    task automatic model_step();
        bit res_rise, cam_rise, disp_rise, toggle;
        if (reset) begin
            m_state = S_CONFIG;
            m_age = 0;
            m_hold_len = 0;
            m_seen_low = 0;
            m_pending = 0;
            m_calib = 1;
            m_err = 0;
            m_btn_prev = 0;
            m_disp_prev = 0;
            cam_h[0] = 0;
            cam_h[1] = 0;
            cam_h[2] = 0;
        end else begin
            res_rise  = btn_resend && !m_btn_prev;
            cam_rise  = cam_h[1] && !cam_h[2];
            disp_rise = disp_vsync && !m_disp_prev;
            m_hold_len = btn_calib ? m_hold_len + 1 : 0;
            toggle = (m_hold_len == HOLD) && (m_state == S_ARM || m_state == S_RUN);
            if (res_rise && m_state != S_CONFIG) begin
                m_state = S_CONFIG;
                m_age = 0;
                m_err = 0;
                m_pending = 0;
            end else begin
                if (disp_rise && m_pending) begin
                    m_calib = !m_calib;
                    m_pending = 0;
                end
                if (toggle) m_pending = !m_pending;
                case (m_state)
                    S_CONFIG: begin
                        m_age++;
                        if (m_age == PULSE) begin
                            m_state = S_WAIT;
                            m_age = 0;
                            m_seen_low = 0;
                        end
                    end
                    S_WAIT: begin
                        if (config_done && m_seen_low) begin
                            m_state = S_ARM;
                        end else begin
                            m_age++;
                            if (m_age == TMO) begin
                                m_state = S_ERROR;
                                m_err = 1;
                            end
                        end
                        if (!config_done) m_seen_low = 1;
                    end
                    S_ARM: if (cam_rise) m_state = S_RUN;
                    default: ;
                endcase
            end
            m_btn_prev  = btn_resend;
            m_disp_prev = disp_vsync;
            cam_h[2] = cam_h[1];
            cam_h[1] = cam_h[0];
            cam_h[0] = cam_vsync;
        end
    endtask

    task automatic cyc(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            model_step();
            e.e_state  = m_state;
            e.e_resend = (m_state == S_CONFIG);
            e.e_cap    = (m_state == S_RUN);
            e.e_calib  = m_calib;
            e.e_err    = m_err;
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic press(input int n);
        btn_calib = 1'b1;
        cyc(n);
        btn_calib = 1'b0;
        cyc(2);
    endtask

    task automatic disp_pulse();
        disp_vsync = 1'b1;
        cyc(1);
        disp_vsync = 1'b0;
        cyc(3);
    endtask

    task automatic resend_pulse();
        btn_resend = 1'b1;
        cyc(1);
        btn_resend = 1'b0;
        cyc(1);
    endtask

    task automatic bring_up();
        config_done = 1'b0;
        cyc(PULSE + 2);
        config_done = 1'b1;
        cyc(2);
        cam_vsync = 1'b1;
        cyc(4);
        cam_vsync = 1'b0;
        cyc(2);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({state, cfg_resend, capture_en, calib, cfg_error} !== e) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d: got state=%0d resend=%b cap=%b calib=%b err=%b, want state=%0d resend=%b cap=%b calib=%b err=%b",
                             phase, cycle, state, cfg_resend, capture_en, calib, cfg_error,
                             e.e_state, e.e_resend, e.e_cap, e.e_calib, e.e_err);
                end
            end
        end
    end

    // Stimulus
    initial begin
        phase = "reset";
        config_done = 1'b1;
        cyc(3);
        reset = 1'b0;

        phase = "config_pulse_stale_done";
        cyc(PULSE + 12);
        phase = "done_handshake";
        config_done = 1'b0;
        cyc(2);
        config_done = 1'b1;
        cyc(2);
        phase = "cam_arm";
        cam_vsync = 1'b1;
        cyc(5);
        cam_vsync = 1'b0;
        cyc(2);

        phase = "short_press";
        press(HOLD - 1);
        disp_pulse();
        phase = "exact_press";
        press(HOLD);
        cyc(5);
        disp_pulse();
        phase = "long_press";
        press(40);
        disp_pulse();
        disp_pulse();
        phase = "double_press_cancel";
        press(HOLD);
        press(HOLD);
        disp_pulse();

        phase = "timeout";
        config_done = 1'b0;
        resend_pulse();
        cyc(PULSE + TMO + 5);
        phase = "error_resend";
        resend_pulse();
        cyc(3);
        bring_up();

        phase = "resend_vs_pending";
        press(HOLD);
        disp_vsync = 1'b1;
        btn_resend = 1'b1;
        cyc(1);
        disp_vsync = 1'b0;
        btn_resend = 1'b0;
        cyc(3);
        bring_up();
        disp_pulse();

        phase = "vsync_with_toggle";
        press(HOLD);
        btn_calib = 1'b1;
        cyc(HOLD - 1);
        disp_vsync = 1'b1;
        cyc(1);
        btn_calib = 1'b0;
        disp_vsync = 1'b0;
        cyc(3);
        disp_pulse();

        phase = "reset_in_run";
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(3);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) btn_calib = ~btn_calib;
            if ($urandom_range(0, 149) == 0) btn_resend = ~btn_resend;
            if ($urandom_range(0, 9) == 0) config_done = ~config_done;
            if ($urandom_range(0, 7) == 0) cam_vsync = ~cam_vsync;
            if ($urandom_range(0, 14) == 0) disp_vsync = ~disp_vsync;
            cyc(1);
        end
        reset = 1'b0;
        cyc(2);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
